// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_e;

    typedef struct packed {
        logic overrun;
        logic parity_err;
        logic framing_err;
    } rx_status_t;

    function automatic int unsigned frame_width(input int unsigned data_bits,
                                                input parity_e     parity,
                                                input int unsigned stop_bits);
        int unsigned par_bits;
        par_bits = (parity != PAR_NONE) ? 32'd1 : 32'd0;
        return 32'd1 + data_bits + par_bits + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with registered storage; head is visible without a read strobe.
module uart_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_wr, do_rd;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rd_data = mem_q[rd_ptr_q];

    // A write into a full FIFO is allowed only when the head leaves in the same cycle.
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wr_data;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_rd) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer: field slicing, framing/parity checks, overrun tracking
// and a small output FIFO for a valid/ready consumer.
module uart_rx_deframer
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS  = 8,
    parameter parity_e     PARITY     = PAR_EVEN,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [frame_width(DATA_BITS, PARITY, STOP_BITS)-1:0] frame_in,
    input  logic                 frame_valid,
    input  logic                 clear_err,
    output logic [DATA_BITS-1:0] out_data,
    output logic [2:0]           out_status,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 done_flag,
    output logic                 overrun_err,
    output logic [CNT_W-1:0]     frame_cnt,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam int unsigned FRAME_W = frame_width(DATA_BITS, PARITY, STOP_BITS);
    localparam int unsigned ENTRY_W = DATA_BITS + $bits(rx_status_t);

    if (DATA_BITS < 5 || DATA_BITS > 9) begin : gen_bad_data_bits
        $error("uart_rx_deframer: DATA_BITS must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : gen_bad_stop_bits
        $error("uart_rx_deframer: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : gen_bad_depth
        $error("uart_rx_deframer: FIFO_DEPTH must be a power of 2, at least 2");
    end

    logic [DATA_BITS-1:0] in_data;
    logic [STOP_BITS-1:0] in_stop;
    logic                 in_par, in_perr, in_ferr;

    always_comb begin
        in_data = frame_in[DATA_BITS:1];
        in_stop = frame_in[FRAME_W-1 -: STOP_BITS];
        in_par  = (PARITY == PAR_NONE) ? 1'b0 : frame_in[DATA_BITS+1];
        in_ferr = frame_in[0] | ~(&in_stop);
        unique case (PARITY)
            PAR_EVEN: in_perr = ^{in_data, in_par};
            PAR_ODD:  in_perr = ~^{in_data, in_par};
            default:  in_perr = 1'b0;
        endcase
    end

    // Capture stage
    logic                 cap_valid_q, cap_perr_q, cap_ferr_q;
    logic [DATA_BITS-1:0] cap_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_valid_q <= 1'b0;
            cap_data_q  <= '0;
            cap_perr_q  <= 1'b0;
            cap_ferr_q  <= 1'b0;
        end else begin
            cap_valid_q <= frame_valid;
            if (frame_valid) begin
                cap_data_q <= in_data;
                cap_perr_q <= in_perr;
                cap_ferr_q <= in_ferr;
            end
        end
    end

    // Push stage
    logic               fifo_full, fifo_empty, pop, push, drop;
    logic [ENTRY_W-1:0] wr_entry, rd_entry;
    rx_status_t         wr_status;
    logic               done_d, done_q, pend_ovr_d, pend_ovr_q, overrun_d, overrun_q;
    logic [CNT_W-1:0]   frame_cnt_d, frame_cnt_q, err_cnt_d, err_cnt_q;

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign push      = cap_valid_q && (!fifo_full || pop);
    assign drop      = cap_valid_q && fifo_full && !pop;

    always_comb begin
        wr_status = '{overrun: pend_ovr_q, parity_err: cap_perr_q, framing_err: cap_ferr_q};
        wr_entry  = {cap_data_q, wr_status};
        done_d    = push;
        // The overrun marker rides on the first frame that makes it in after a drop.
        pend_ovr_d = pend_ovr_q;
        if (drop) begin
            pend_ovr_d = 1'b1;
        end else if (push) begin
            pend_ovr_d = 1'b0;
        end
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_err) begin
            overrun_d = 1'b0;
        end
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (push && frame_cnt_q != '1) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
        if (push && (cap_perr_q || cap_ferr_q) && err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q      <= 1'b0;
            pend_ovr_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            done_q      <= done_d;
            pend_ovr_q  <= pend_ovr_d;
            overrun_q   <= overrun_d;
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    uart_sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (wr_entry),
        .rd_en   (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_data    = rd_entry[ENTRY_W-1:3];
    assign out_status  = rd_entry[2:0];
    assign done_flag   = done_q;
    assign overrun_err = overrun_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: directed scenarios on the default build plus random
// frames on two alternative builds, all checked against a frame-level model.
module tb_uart_rx_deframer;
    import uart_pkg::*;

    localparam int FW0  = 11;
    localparam int FW_A = 8;
    localparam int FW_B = 13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [FW0-1:0]  f0;
    logic            v0, clr0, rdy0, ov0, done0, oe0;
    logic [7:0]      d0;
    logic [2:0]      s0;
    logic [15:0]     fc0, ec0;

    logic [FW_A-1:0] fa;
    logic            va, ova, dna, oea;
    logic [4:0]      da;
    logic [2:0]      sa;
    logic [15:0]     fca, eca;

    logic [FW_B-1:0] fb;
    logic            vb, ovb, dnb, oeb;
    logic [8:0]      db;
    logic [2:0]      sb;
    logic [15:0]     fcb, ecb;

    logic            clr_x, rdy_x;

    uart_rx_deframer u_dut0 (
        .clk(clk), .rst_n(rst_n), .frame_in(f0), .frame_valid(v0), .clear_err(clr0),
        .out_data(d0), .out_status(s0), .out_valid(ov0), .out_ready(rdy0),
        .done_flag(done0), .overrun_err(oe0), .frame_cnt(fc0), .err_cnt(ec0)
    );

    uart_rx_deframer #(.DATA_BITS(5), .PARITY(PAR_NONE), .STOP_BITS(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .frame_in(fa), .frame_valid(va), .clear_err(clr_x),
        .out_data(da), .out_status(sa), .out_valid(ova), .out_ready(rdy_x),
        .done_flag(dna), .overrun_err(oea), .frame_cnt(fca), .err_cnt(eca)
    );

    uart_rx_deframer #(.DATA_BITS(9), .PARITY(PAR_ODD), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .frame_in(fb), .frame_valid(vb), .clear_err(clr_x),
        .out_data(db), .out_status(sb), .out_valid(ovb), .out_ready(rdy_x),
        .done_flag(dnb), .overrun_err(oeb), .frame_cnt(fcb), .err_cnt(ecb)
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asserts++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Default-build frame: stop, even parity (optionally corrupted), data, start.
    function automatic logic [10:0] mk0(input logic [7:0] d, input logic pbad,
                                        input logic sbad, input logic stbad);
        return {~sbad, (^d) ^ pbad, d, stbad};
    endfunction

    // ptype: 0 none, 1 even, 2 odd. Returns {data[8:0], overrun=0, parity_err, framing_err}.
    function automatic logic [11:0] ref_out(input logic [15:0] fr, input int dbits,
                                            input int ptype, input int sbits);
        int fw;
        int ones;
        logic [8:0] d;
        logic ferr, perr;
        fw   = 1 + dbits + ((ptype != 0) ? 1 : 0) + sbits;
        ones = 0;
        d    = '0;
        for (int i = 0; i < dbits; i++) begin
            d[i] = fr[1+i];
            ones += int'(fr[1+i]);
        end
        if (ptype != 0) ones += int'(fr[dbits+1]);
        ferr = fr[0];
        for (int i = 0; i < sbits; i++) begin
            if (!fr[fw-1-i]) ferr = 1'b1;
        end
        if (ptype == 0)      perr = 1'b0;
        else if (ptype == 1) perr = (ones % 2) != 0;
        else                 perr = (ones % 2) != 1;
        return {d, 1'b0, perr, ferr};
    endfunction

    function automatic logic [15:0] rand_frame(input int dbits, input int ptype, input int sbits);
        int fw;
        logic [15:0] fr;
        fw    = 1 + dbits + ((ptype != 0) ? 1 : 0) + sbits;
        fr    = 16'($urandom);
        fr[0] = ($urandom_range(0, 7) == 0);
        for (int i = 0; i < sbits; i++) begin
            fr[fw-1-i] = ($urandom_range(0, 5) != 0);
        end
        for (int i = fw; i < 16; i++) fr[i] = 1'b0;
        return fr;
    endfunction

    task automatic push0(input logic [10:0] f);
        f0 = f;
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        step();
    endtask

    initial begin
        int ca_f, ca_e, cb_f, cb_e, c0_f, c0_e;
        f0 = '0; v0 = 0; clr0 = 0; rdy0 = 0;
        fa = '0; va = 0; fb = '0; vb = 0; clr_x = 0; rdy_x = 1;
        step(); step();
        check("rst_valid", ov0, 0);
        check("rst_data", d0, 0);
        check("rst_status", s0, 0);
        check("rst_done", done0, 0);
        check("rst_ovr", oe0, 0);
        check("rst_cnts", {fc0, ec0}, 0);
        rst_n = 1'b1;
        step();

        // Clean frame and single-error frames
        rdy0 = 1'b1;
        push0(mk0(8'hA5, 0, 0, 0));
        check("t1_valid", ov0, 1);
        check("t1_data", d0, 8'hA5);
        check("t1_status", s0, 3'b000);
        check("t1_done", done0, 1);
        check("t1_fcnt", fc0, 1);
        step();
        check("t1_popped", ov0, 0);
        check("t1_done_pulse", done0, 0);
        push0(mk0(8'hA5, 1, 0, 0));
        check("t2_par", s0, 3'b010);
        check("t2_ecnt", ec0, 1);
        step();
        push0(mk0(8'hA5, 0, 0, 1));
        check("t2_start", s0, 3'b001);
        step();
        push0(mk0(8'hA5, 0, 1, 0));
        check("t2_stop", s0, 3'b001);
        check("t2_cnts", {fc0, ec0}, {16'd4, 16'd3});
        step();

        // Overrun with a stalled consumer
        rdy0 = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            f0 = mk0(8'(i), 0, 0, 0);
            v0 = 1'b1;
            step();
        end
        v0 = 1'b0;
        step();
        check("t3_ovr", oe0, 1);
        check("t3_drop_done", done0, 0);
        for (int i = 1; i <= 4; i++) begin
            check("t3_drain", {d0, s0}, {8'(i), 3'b000});
            rdy0 = 1'b1;
            step();
        end
        check("t3_empty", ov0, 0);
        push0(mk0(8'h06, 0, 0, 0));
        check("t3_ovr_mark", {d0, s0}, {8'h06, 3'b100});
        check("t3_cnts", {fc0, ec0}, {16'd9, 16'd3});
        step();
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("t3_clear", oe0, 0);

        // Full FIFO with simultaneous push and pop, then clear vs. new overrun
        rdy0 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f0 = mk0(8'h10 + 8'(i), 0, 0, 0);
            v0 = 1'b1;
            step();
        end
        v0 = 1'b0;
        step(); step();
        f0 = mk0(8'h14, 0, 0, 0);
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        rdy0 = 1'b1;
        step();
        rdy0 = 1'b0;
        check("t4_no_ovr", oe0, 0);
        check("t4_done", done0, 1);
        check("t4_head", d0, 8'h11);
        step();
        check("t4_hold", d0, 8'h11);
        f0 = mk0(8'h15, 0, 0, 0);
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        clr0 = 1'b1;
        step();
        clr0 = 1'b0;
        check("t4_set_wins", oe0, 1);
        for (int i = 1; i <= 4; i++) begin
            check("t4_order", d0, 8'h10 + 8'(i));
            rdy0 = 1'b1;
            step();
        end
        check("t4_empty", ov0, 0);
        check("t4_fcnt", fc0, 14);

        // Asynchronous reset with entries queued and a frame in flight
        rdy0 = 1'b0;
        push0(mk0(8'h21, 0, 0, 0));
        push0(mk0(8'h22, 0, 0, 0));
        check("t5_queued", ov0, 1);
        f0 = mk0(8'h23, 0, 0, 0);
        v0 = 1'b1;
        step();
        v0 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid", ov0, 0);
        check("t5_cnts", {fc0, ec0}, 0);
        check("t5_ovr", oe0, 0);
        step();
        rst_n = 1'b1;
        step();
        check("t5_no_ghost", ov0, 0);
        rdy0 = 1'b1;
        push0(mk0(8'h3C, 0, 0, 0));
        check("t5_after", {ov0, d0, s0}, {1'b1, 8'h3C, 3'b000});
        check("t5_fcnt", fc0, 1);
        step();

        // Random frames on all three builds
        ca_f = 0; ca_e = 0; cb_f = 0; cb_e = 0; c0_f = 1; c0_e = 0;
        for (int it = 0; it < 40; it++) begin
            logic [15:0] r0, ra, rb;
            logic [11:0] e0, ea, eb;
            r0 = rand_frame(8, 1, 1);
            ra = rand_frame(5, 0, 2);
            rb = rand_frame(9, 2, 2);
            e0 = ref_out(r0, 8, 1, 1);
            ea = ref_out(ra, 5, 0, 2);
            eb = ref_out(rb, 9, 2, 2);
            f0 = r0[FW0-1:0];
            fa = ra[FW_A-1:0];
            fb = rb[FW_B-1:0];
            v0 = 1'b1; va = 1'b1; vb = 1'b1;
            step();
            v0 = 1'b0; va = 1'b0; vb = 1'b0;
            step();
            check("rnd_d8", {1'b0, d0, s0}, e0);
            check("rnd_d5", {4'b0, da, sa}, ea);
            check("rnd_d9", {db, sb}, eb);
            c0_f++; ca_f++; cb_f++;
            if (e0[1:0] != 0) c0_e++;
            if (ea[1:0] != 0) ca_e++;
            if (eb[1:0] != 0) cb_e++;
        end
        fa = {1'b0, 1'b1, 5'b10110, 1'b0};
        va = 1'b1;
        step();
        va = 1'b0;
        step();
        check("a_stop2", {da, sa}, {5'b10110, 3'b001});
        ca_f++; ca_e++;
        step();
        check("rnd_cnt0", {fc0, ec0}, {16'(c0_f), 16'(c0_e)});
        check("rnd_cnt_a", {fca, eca}, {16'(ca_f), 16'(ca_e)});
        check("rnd_cnt_b", {fcb, ecb}, {16'(cb_f), 16'(cb_e)});

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
